ball_sprite_engine: RTL and testbench
=====================================

// Module: ball_sprite_engine
// PURPOSE
//  Parametrised multi-ball sprite engine, successor to the single bouncing-ball top level.
//  Consumes hpos/vpos/display_on/hsync/vsync from hvsync_generator and keeps NUM_BALLS
//  independent balls, each bouncing off all four screen edges. Ball state updates once
//  per frame, fully synchronous to clk_i with no vsync-clocked or collision-clocked flops.
//  Drives 24-bit RGB, with sync delayed to match, into the video output path.
// PARAMETERS
//  NUM_BALLS   4    number of balls, 1..8
//  POS_W       9    width of hpos/vpos, ball positions and velocities
//  SCREEN_W    320  active width in pixels
//  SCREEN_H    240  active height in pixels
//  BALL_SIZE   4    ball edge length in pixels; MAX_X=SCREEN_W-BALL_SIZE, MAX_Y=SCREEN_H-BALL_SIZE
//  SPEED       2    initial velocity magnitude per frame; must be < MAX_X and < MAX_Y
// PORTS
//  clk_i         in   1      pixel clock
//  rst_ni        in   1      synchronous reset, active low
//  hpos_i        in   POS_W  beam X from hvsync_generator
//  vpos_i        in   POS_W  beam Y from hvsync_generator
//  display_on_i  in   1      active-video flag
//  hsync_i       in   1      horizontal sync in
//  vsync_i       in   1      vertical sync in; its rising edge triggers the frame update
//  pause_i       in   1      level: while high, frame updates are suppressed
//  step_i        in   1      one-cycle pulse: allow exactly one update while paused
//  hsync_o       out  1      hsync_i delayed 1 cycle
//  vsync_o       out  1      vsync_i delayed 1 cycle
//  rgb_o         out  24     pixel colour {R,G,B}, 8 bits each
//  frame_done_o  out  1      one-cycle pulse when a frame update completes
//  bounce_o      out  1      one-cycle pulse, coincident with frame_done_o, if any ball reflected
// BEHAVIOUR
//  - Reset (rst_ni=0 at a clk_i edge) takes priority over everything, including mid-update:
//    FSM=IDLE, index=0, step_pending=0, vsync_q=1, rgb_o=0, hsync_o=0, vsync_o=0,
//    frame_done_o=0, bounce_o=0, bounce_acc=0.
//    Ball i: x=16+32*i, y=16+24*i; vx=+SPEED if i is even, -SPEED if odd; vy=+SPEED.
//  - Velocities are signed POS_W bits. Positions are unsigned POS_W bits.
//  - Trigger condition: vsync_i=1 and vsync_q=0, where vsync_q is vsync_i registered.
//    vsync_q resets to 1, so vsync held high through reset release gives no trigger.
//  - step_i sets step_pending. step_pending clears when an update starts.
//  - FSM IDLE: on trigger, if (!pause_i || step_pending) go to UPDATE with index=0.
//    Otherwise the trigger is ignored.
//  - FSM UPDATE: updates ball[index] in one cycle, then index++.
//    After index NUM_BALLS-1 go to DONE. UPDATE lasts NUM_BALLS cycles.
//  - FSM DONE: for one cycle, frame_done_o=1 and bounce_o=bounce_acc.
//    bounce_acc clears, then go to IDLE. A trigger seen in UPDATE or DONE is dropped.
//  - Per-axis update, shown for X (Y is identical using MAX_Y):
//    vx<0 and x<|vx|          -> x=0,     vx=-vx, flag bounce
//    vx>0 and x+vx>MAX_X      -> x=MAX_X, vx=-vx, flag bounce (sum taken in POS_W+1 bits)
//    otherwise                -> x=x+vx
//    Landing exactly on 0 or MAX_X is not a bounce. A ball may bounce on both axes in one update.
//  - Pixel path, registered, 1-cycle latency from hpos_i/vpos_i to rgb_o:
//    hit_i = (hpos-x_i) < BALL_SIZE && (vpos-y_i) < BALL_SIZE, differences taken mod 2^POS_W.
//    Colour index c_i = (i mod 7)+1. R=c_i[2], G=c_i[1], B=c_i[0], each bit expanded to 8'hFF/8'h00.
//    Overlapping balls: the lowest index wins.
//    No ball hit: grid pixel (hpos[2:0]==0 && vpos[2:0]==0) gives 24'h00FF00, otherwise 0.
//    display_on_i=0 forces rgb_o=0.
//  - Position reads by the pixel path during UPDATE see old or new values per ball. This is
//    acceptable because updates happen in blanking.
// TESTING
//  T1 reset (NUM_BALLS=4): hold rst_ni=0, release; drive hpos=16, vpos=16, display_on=1
//     -> next cycle rgb_o=24'h0000FF (ball 0, c=1); hpos=48, vpos=40 -> 24'h00FF00 (ball 1, c=2).
//  T2 single frame: one vsync rising edge, pause_i=0 -> after NUM_BALLS+1 cycles, one
//     frame_done_o pulse; ball0=(18,18), ball1=(46,42); bounce_o=0.
//  T3 right wall: force ball0 x=314, vx=+2 -> frame: x=316, no bounce; next frame:
//     x=316, vx=-2, bounce_o=1. Left wall: x=1, vx=-2 -> x=0, vx=+2, bounce_o=1.
//  T4 pause/step: pause_i=1, 3 vsync edges -> no frame_done_o, positions unchanged; pulse
//     step_i, 2 edges -> exactly one update; then pause_i=0 -> updates on every edge.
//  T5 overlap: place ball0 and ball2 at the same (100,100) -> rgb_o=24'h0000FF (ball 0 wins);
//     display_on=0 at that pixel -> rgb_o=0.
//  T6 reset mid-update: assert rst_ni=0 on the 2nd UPDATE cycle -> all balls at initial values,
//     no frame_done_o pulse; vsync held high across release -> no update until the next rising edge.

Source files
------------

// File: rtl/ball_sprite_engine.sv
// ball_sprite_engine: multi-ball bouncing sprite renderer with once-per-frame state updates
module ball_sprite_engine #(
    parameter int NUM_BALLS = 4,
    parameter int POS_W     = 9,
    parameter int SCREEN_W  = 320,
    parameter int SCREEN_H  = 240,
    parameter int BALL_SIZE = 4,
    parameter int SPEED     = 2
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [POS_W-1:0] hpos_i,
    input  logic [POS_W-1:0] vpos_i,
    input  logic             display_on_i,
    input  logic             hsync_i,
    input  logic             vsync_i,
    input  logic             pause_i,
    input  logic             step_i,
    output logic             hsync_o,
    output logic             vsync_o,
    output logic [23:0]      rgb_o,
    output logic             frame_done_o,
    output logic             bounce_o
);
    localparam int IDX_W = NUM_BALLS > 1 ? $clog2(NUM_BALLS) : 1;
    localparam logic [POS_W-1:0] MAX_X = POS_W'(SCREEN_W - BALL_SIZE);
    localparam logic [POS_W-1:0] MAX_Y = POS_W'(SCREEN_H - BALL_SIZE);

    typedef enum logic [1:0] {IDLE, UPDATE, DONE} state_t;

    state_t                  state_q, state_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic                    step_pending_q, step_pending_d;
    logic                    bounce_acc_q, bounce_acc_d;
    logic                    vsync_q, hsync_dly_q, vsync_dly_q;
    logic [23:0]             rgb_q, rgb_d, pix;
    logic [POS_W-1:0]        x_q [NUM_BALLS];
    logic [POS_W-1:0]        x_d [NUM_BALLS];
    logic [POS_W-1:0]        y_q [NUM_BALLS];
    logic [POS_W-1:0]        y_d [NUM_BALLS];
    logic signed [POS_W-1:0] vx_q [NUM_BALLS];
    logic signed [POS_W-1:0] vx_d [NUM_BALLS];
    logic signed [POS_W-1:0] vy_q [NUM_BALLS];
    logic signed [POS_W-1:0] vy_d [NUM_BALLS];
    logic [NUM_BALLS-1:0]    hit;
    logic                    trigger, bx, by;

    // Returns {bounced, new_pos, new_vel}; the sum is widened so it cannot wrap past the wall.
    function automatic logic [2*POS_W:0] axis_step(input logic [POS_W-1:0] p,
                                                  input logic signed [POS_W-1:0] v,
                                                  input logic [POS_W-1:0] lim);
        logic [POS_W-1:0] mag;
        logic [POS_W:0]   sum;
        mag = v[POS_W-1] ? -v : v;
        sum = {1'b0, p} + {1'b0, v};
        if (v[POS_W-1] && p < mag) return {1'b1, {POS_W{1'b0}}, -v};
        if (!v[POS_W-1] && sum > {1'b0, lim}) return {1'b1, lim, -v};
        return {1'b0, p + v, v};
    endfunction

    function automatic logic [23:0] colour(input int i);
        logic [2:0] c;
        c = 3'((i % 7) + 1);
        return {{8{c[2]}}, {8{c[1]}}, {8{c[0]}}};
    endfunction

    always_comb begin
        trigger        = vsync_i && !vsync_q;
        state_d        = state_q;
        idx_d          = idx_q;
        step_pending_d = step_pending_q || step_i;
        bounce_acc_d   = bounce_acc_q;
        x_d            = x_q;
        y_d            = y_q;
        vx_d           = vx_q;
        vy_d           = vy_q;
        bx             = 1'b0;
        by             = 1'b0;
        case (state_q)
            IDLE: if (trigger && (!pause_i || step_pending_q)) begin
                state_d        = UPDATE;
                idx_d          = '0;
                step_pending_d = 1'b0;
            end
            UPDATE: begin
                for (int i = 0; i < NUM_BALLS; i++) begin
                    if (idx_q == IDX_W'(i)) begin
                        {bx, x_d[i], vx_d[i]} = axis_step(x_q[i], vx_q[i], MAX_X);
                        {by, y_d[i], vy_d[i]} = axis_step(y_q[i], vy_q[i], MAX_Y);
                    end
                end
                bounce_acc_d = bounce_acc_q || bx || by;
                idx_d        = idx_q + IDX_W'(1);
                state_d      = idx_q == IDX_W'(NUM_BALLS - 1) ? DONE : UPDATE;
            end
            default: begin
                bounce_acc_d = 1'b0;
                state_d      = IDLE;
            end
        endcase
    end

    for (genvar b = 0; b < NUM_BALLS; b++) begin : g_hit
        assign hit[b] = (hpos_i - x_q[b]) < POS_W'(BALL_SIZE) && (vpos_i - y_q[b]) < POS_W'(BALL_SIZE);
    end

    // Scan from the top index down so the lowest-numbered ball overwrites the others.
    always_comb begin
        pix = (hpos_i[2:0] == 3'd0 && vpos_i[2:0] == 3'd0) ? 24'h00FF00 : 24'h000000;
        for (int i = NUM_BALLS - 1; i >= 0; i--) begin
            if (hit[i]) pix = colour(i);
        end
        rgb_d = display_on_i ? pix : 24'h000000;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q        <= IDLE;
            idx_q          <= '0;
            step_pending_q <= 1'b0;
            bounce_acc_q   <= 1'b0;
            vsync_q        <= 1'b1;
            hsync_dly_q    <= 1'b0;
            vsync_dly_q    <= 1'b0;
            rgb_q          <= '0;
            for (int i = 0; i < NUM_BALLS; i++) begin
                x_q[i]  <= POS_W'(16 + 32 * i);
                y_q[i]  <= POS_W'(16 + 24 * i);
                vx_q[i] <= (i % 2 == 1) ? -POS_W'(SPEED) : POS_W'(SPEED);
                vy_q[i] <= POS_W'(SPEED);
            end
        end else begin
            state_q        <= state_d;
            idx_q          <= idx_d;
            step_pending_q <= step_pending_d;
            bounce_acc_q   <= bounce_acc_d;
            vsync_q        <= vsync_i;
            hsync_dly_q    <= hsync_i;
            vsync_dly_q    <= vsync_i;
            rgb_q          <= rgb_d;
            x_q            <= x_d;
            y_q            <= y_d;
            vx_q           <= vx_d;
            vy_q           <= vy_d;
        end
    end

    assign hsync_o      = hsync_dly_q;
    assign vsync_o      = vsync_dly_q;
    assign rgb_o        = rgb_q;
    assign frame_done_o = state_q == DONE;
    assign bounce_o     = frame_done_o && bounce_acc_q;
endmodule

// File: tb/tb_ball_sprite_engine.sv
// tb_ball_sprite_engine: scoreboard bench driving three engine configurations against a frame-level model
module tb_ball_sprite_engine;
    localparam int NA [3] = '{4, 8, 3};
    localparam int SP [3] = '{2, 3, 5};
    localparam int BS [3] = '{4, 4, 40};

    logic       clk = 1'b0, rst_n = 1'b0;
    logic [8:0] hpos = '0, vpos = '0;
    logic       disp = 1'b0, hs = 1'b0, vs = 1'b0, pause = 1'b0, step = 1'b0;
    logic [23:0] rgb [3];
    logic       hs_o [3], vs_o [3], done [3], bnc [3];

    always #5 clk = ~clk;

    ball_sprite_engine dut_a (
        .clk_i(clk), .rst_ni(rst_n), .hpos_i(hpos), .vpos_i(vpos), .display_on_i(disp),
        .hsync_i(hs), .vsync_i(vs), .pause_i(pause), .step_i(step),
        .hsync_o(hs_o[0]), .vsync_o(vs_o[0]), .rgb_o(rgb[0]), .frame_done_o(done[0]), .bounce_o(bnc[0]));
    ball_sprite_engine #(.NUM_BALLS(8), .SPEED(3)) dut_b (
        .clk_i(clk), .rst_ni(rst_n), .hpos_i(hpos), .vpos_i(vpos), .display_on_i(disp),
        .hsync_i(hs), .vsync_i(vs), .pause_i(pause), .step_i(step),
        .hsync_o(hs_o[1]), .vsync_o(vs_o[1]), .rgb_o(rgb[1]), .frame_done_o(done[1]), .bounce_o(bnc[1]));
    ball_sprite_engine #(.NUM_BALLS(3), .SPEED(5), .BALL_SIZE(40)) dut_c (
        .clk_i(clk), .rst_ni(rst_n), .hpos_i(hpos), .vpos_i(vpos), .display_on_i(disp),
        .hsync_i(hs), .vsync_i(vs), .pause_i(pause), .step_i(step),
        .hsync_o(hs_o[2]), .vsync_o(vs_o[2]), .rgb_o(rgb[2]), .frame_done_o(done[2]), .bounce_o(bnc[2]));

    typedef struct {int cyc; logic [2:0][23:0] e;} pix_t;
    typedef struct {int cyc; logic [2:0] b;} ev_t;

    int   mx [3][8], my [3][8], mvx [3][8], mvy [3][8];
    bit   step_m;
    int   cyc = 0, checks = 0, errors = 0;
    pix_t pq[$];
    ev_t  eq[$];
    logic [2:0] seen = '0;

    function automatic void model_reset();
        for (int k = 0; k < 3; k++)
            for (int i = 0; i < NA[k]; i++) begin
                mx[k][i]  = 16 + 32 * i;
                my[k][i]  = 16 + 24 * i;
                mvx[k][i] = (i % 2 == 1) ? -SP[k] : SP[k];
                mvy[k][i] = SP[k];
            end
        step_m = 0;
    endfunction

    function automatic bit bounce_axis(inout int p, inout int v, input int lim);
        if (v < 0 && p < -v) begin p = 0; v = -v; return 1; end
        if (v > 0 && p + v > lim) begin p = lim; v = -v; return 1; end
        p = p + v;
        return 0;
    endfunction

    function automatic bit model_frame(int k);
        bit any, b1, b2;
        int p, v;
        any = 0;
        for (int i = 0; i < NA[k]; i++) begin
            p = mx[k][i]; v = mvx[k][i];
            b1 = bounce_axis(p, v, 320 - BS[k]);
            mx[k][i] = p; mvx[k][i] = v;
            p = my[k][i]; v = mvy[k][i];
            b2 = bounce_axis(p, v, 240 - BS[k]);
            my[k][i] = p; mvy[k][i] = v;
            any = any | b1 | b2;
        end
        return any;
    endfunction

    function automatic logic [23:0] exp_rgb(int k, int h, int v, bit d);
        int c;
        if (!d) return 24'h0;
        for (int i = 0; i < NA[k]; i++)
            if (((h - mx[k][i]) & 511) < BS[k] && ((v - my[k][i]) & 511) < BS[k]) begin
                c = i % 7 + 1;
                return {c[2] ? 8'hFF : 8'h00, c[1] ? 8'hFF : 8'h00, c[0] ? 8'hFF : 8'h00};
            end
        return (h % 8 == 0 && v % 8 == 0) ? 24'h00FF00 : 24'h0;
    endfunction

    task automatic check_bit(string name, int k, logic got, logic exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s[%0d] cycle %0d: got %b expected %b", name, k, cyc, got, exp);
        end
    endtask

    task automatic probe(int h, int v, bit d);
        pix_t p;
        hpos = 9'(h); vpos = 9'(v); disp = d; hs = 1'($urandom_range(0, 1));
        p.cyc = cyc + 1;
        for (int k = 0; k < 3; k++) p.e[k] = exp_rgb(k, h, v, d);
        pq.push_back(p);
        @(negedge clk);
    endtask

    task automatic random_probe();
        int k, i;
        k = int'($urandom_range(0, 2));
        i = int'($urandom_range(0, NA[k] - 1));
        if ($urandom_range(0, 3) == 0)
            probe(int'($urandom_range(0, 63)) * 8 + int'($urandom_range(0, 1)), int'($urandom_range(0, 63)) * 8, 1'b1);
        else
            probe((mx[k][i] + int'($urandom_range(0, BS[k] + 1)) - 1) & 511,
                  (my[k][i] + int'($urandom_range(0, BS[k] + 1)) - 1) & 511, $urandom_range(0, 7) != 0);
    endtask

    task automatic frame();
        ev_t e;
        vs = 1'b1;
        if (!pause || step_m) begin
            step_m = 0;
            e.cyc = cyc + 1;
            for (int k = 0; k < 3; k++) e.b[k] = model_frame(k);
            eq.push_back(e);
        end
        repeat (12) begin hs = 1'($urandom_range(0, 1)); @(negedge clk); end
        vs = 1'b0;
        @(negedge clk);
    endtask

    task automatic pulse_step();
        step = 1'b1;
        @(negedge clk);
        step = 1'b0;
        step_m = 1;
        @(negedge clk);
    endtask

    initial begin : monitor
        pix_t p;
        int tgt;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            for (int k = 0; k < 3; k++) begin
                check_bit("hsync_o", k, hs_o[k], rst_n & hs);
                check_bit("vsync_o", k, vs_o[k], rst_n & vs);
                tgt = eq.size() > 0 ? eq[0].cyc + NA[k] : -1;
                if (done[k]) begin
                    checks++;
                    if (eq.size() == 0 || seen[k] || cyc != tgt) begin
                        errors++;
                        $display("FAIL frame_done[%0d] cycle %0d: got 1 expected 0", k, cyc);
                    end else begin
                        seen[k] = 1'b1;
                        check_bit("bounce_o", k, bnc[k], eq[0].b[k]);
                    end
                end else begin
                    check_bit("bounce_idle", k, bnc[k], 1'b0);
                    if (tgt >= 0 && !seen[k] && cyc >= tgt) begin
                        checks++; errors++;
                        $display("FAIL frame_done[%0d] cycle %0d: got 0 expected 1", k, cyc);
                        seen[k] = 1'b1;
                    end
                end
            end
            if (eq.size() > 0 && seen == 3'b111) begin
                void'(eq.pop_front());
                seen = '0;
            end
            while (pq.size() > 0 && pq[0].cyc <= cyc) begin
                p = pq.pop_front();
                for (int k = 0; k < 3; k++) begin
                    checks++;
                    if (p.cyc != cyc || rgb[k] !== p.e[k]) begin
                        errors++;
                        $display("FAIL rgb[%0d] cycle %0d (due %0d): got %h expected %h", k, cyc, p.cyc, rgb[k], p.e[k]);
                    end
                end
            end
        end
    end

    initial begin : stimulus
        model_reset();
        hpos = 9'd16; vpos = 9'd16; disp = 1'b1;
        repeat (4) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (rgb[k] !== 24'h0) begin
                errors++;
                $display("FAIL reset_rgb[%0d]: got %h expected 000000", k, rgb[k]);
            end
            check_bit("reset_done", k, done[k], 1'b0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        probe(16, 16, 1'b1);
        probe(48, 40, 1'b1);
        probe(48, 40, 1'b0);
        probe(50, 45, 1'b1);
        probe(50, 45, 1'b0);
        probe(0, 0, 1'b1);
        probe(1, 0, 1'b1);
        frame();
        probe(18, 18, 1'b1);
        probe(46, 42, 1'b1);
        probe(17, 18, 1'b1);
        pause = 1'b1;
        repeat (3) frame();
        probe(18, 18, 1'b1);
        pulse_step();
        repeat (2) frame();
        probe(20, 20, 1'b1);
        pause = 1'b0;
        repeat (3) begin frame(); random_probe(); end
        // Reset lands on the second update cycle; vsync stays high through release.
        vs = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        repeat (8) @(negedge clk);
        probe(16, 16, 1'b1);
        probe(48, 40, 1'b1);
        vs = 1'b0;
        @(negedge clk);
        frame();
        probe(18, 18, 1'b1);
        for (int n = 0; n < 260; n++) begin
            pause = $urandom_range(0, 7) == 0;
            if ($urandom_range(0, 5) == 0) pulse_step();
            frame();
            repeat (4) random_probe();
        end
        pause = 1'b0;
        repeat (15) @(negedge clk);
        checks++;
        if (pq.size() != 0 || eq.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d/%0d pending expected 0/0", pq.size(), eq.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
